pc_fetch_ctrl: RTL and testbench

Next-PC sequencer and fetch controller for the 16-bit single-cycle core. It owns the PC register and selects each cycle between sequential fetch (PC+2), a PC-relative branch (B), a register branch (BR), hold (stall) and halt. Condition evaluation against the N/Z/V flags is done here. The block also keeps a saturating count of taken branches for bring-up debug.

---
 rtl/pc_fetch_ctrl.sv | 103 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencer and fetch controller for the 16-bit single-cycle core.
// Owns the PC, evaluates branch conditions and counts taken branches.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             br_valid,
  input  logic             br_type,
  input  logic [2:0]       ccc,
  input  logic [2:0]       flags,
  input  logic [8:0]       imm9,
  input  logic [15:0]      br_reg,
  output logic [15:0]      pc_out,
  output logic [15:0]      pc_plus2,
  output logic             taken,
  output logic             halted,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] br_count
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       pc;
  logic [15:0]       pc_nxt;
  logic [15:0]       b_off;
  logic [15:0]       target;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              cond;
  logic              run;
  logic              f_n;
  logic              f_z;
  logic              f_v;

  assign f_n = flags[2];
  assign f_z = flags[1];
  assign f_v = flags[0];

  always_comb begin
    cond = 1'b0;
    case (ccc)
      3'b000: cond = ~f_z;
      3'b001: cond = f_z;
      3'b010: cond = ~f_z & ~f_n;
      3'b011: cond = f_n;
      3'b100: cond = f_z | (~f_z & ~f_n);
      3'b101: cond = f_n | f_z;
      3'b110: cond = f_v;
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign run      = (state == RUN);
  assign pc_plus2 = pc + 16'd2;
  // Word offset: sign-extend then scale to bytes.
  assign b_off    = {{6{imm9[8]}}, imm9, 1'b0};
  assign target   = br_type ? br_reg : (pc_plus2 + b_off);
  assign taken    = run & ~stall & ~halt_req & br_valid & cond;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_plus2;
    cnt_nxt   = cnt;
    if (!run || stall) begin
      pc_nxt = pc;
    end else if (halt_req) begin
      pc_nxt    = pc;
      state_nxt = HALT;
    end else if (taken) begin
      pc_nxt = target;
      if (cnt != '1)
        cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign pc_out      = pc;
  assign halted      = (state == HALT);
  assign fetch_valid = run & ~stall;
  assign br_count    = cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; a second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt_req;
  logic        br_valid;
  logic        br_type;
  logic [2:0]  ccc;
  logic [2:0]  flags;
  logic [8:0]  imm9;
  logic [15:0] br_reg;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        taken;
  logic        halted;
  logic        fetch_valid;
  logic [15:0] br_count;
  logic [15:0] pc_out2;
  logic [15:0] pc_plus2_2;
  logic        taken2;
  logic        halted2;
  logic        fetch_valid2;
  logic [1:0]  br_count2;

  int checks;
  int failures;
  int exp_cnt;

  pc_fetch_ctrl #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .br_valid(br_valid), .br_type(br_type), .ccc(ccc), .flags(flags),
    .imm9(imm9), .br_reg(br_reg), .pc_out(pc_out), .pc_plus2(pc_plus2),
    .taken(taken), .halted(halted), .fetch_valid(fetch_valid),
    .br_count(br_count)
  );

  pc_fetch_ctrl #(.RESET_PC(16'h0000), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .br_valid(br_valid), .br_type(br_type), .ccc(ccc), .flags(flags),
    .imm9(imm9), .br_reg(br_reg), .pc_out(pc_out2),
    .pc_plus2(pc_plus2_2), .taken(taken2), .halted(halted2),
    .fetch_valid(fetch_valid2), .br_count(br_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall    = 1'b0;
    halt_req = 1'b0;
    br_valid = 1'b0;
    br_type  = 1'b0;
    ccc      = 3'b000;
    flags    = 3'b000;
    imm9     = 9'h000;
    br_reg   = 16'h0000;
  endtask

  task automatic br_to(input logic [15:0] addr);
    br_valid = 1'b1;
    br_type  = 1'b1;
    ccc      = 3'b111;
    br_reg   = addr;
    tick();
    idle();
    exp_cnt++;
    chk("br_to_pc", {16'h0, pc_out}, {16'h0, addr});
  endtask

  function automatic logic ref_cond(input logic [2:0] c,
                                    input logic n, input logic z,
                                    input logic v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and free-running fetch
    chk("rst_pc", {16'h0, pc_out}, 32'h0000);
    chk("rst_pc2", {16'h0, pc_plus2}, 32'h0002);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_fv", {31'h0, fetch_valid}, 32'h1);
    chk("rst_cnt", {16'h0, br_count}, 32'h0);
    tick();
    chk("seq1", {16'h0, pc_out}, 32'h0002);
    tick();
    chk("seq2", {16'h0, pc_out}, 32'h0004);
    tick();
    chk("seq3", {16'h0, pc_out}, 32'h0006);

    // B taken on Z=1, backward offset
    br_to(16'h0010);
    br_valid = 1'b1;
    br_type  = 1'b0;
    ccc      = 3'b001;
    flags    = 3'b010;
    imm9     = 9'h1FC;
    #1;
    chk("b_taken", {31'h0, taken}, 32'h1);
    tick();
    idle();
    exp_cnt++;
    chk("b_target", {16'h0, pc_out}, 32'h000A);

    // Same B not taken on Z=0
    br_to(16'h0010);
    br_valid = 1'b1;
    br_type  = 1'b0;
    ccc      = 3'b001;
    flags    = 3'b000;
    imm9     = 9'h1FC;
    #1;
    chk("b_nottaken", {31'h0, taken}, 32'h0);
    tick();
    idle();
    chk("b_fall", {16'h0, pc_out}, 32'h0012);

    // BR then stall with a pending branch
    br_to(16'h0020);
    br_to(16'h1234);
    chk("br_cnt", {16'h0, br_count}, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      stall    = 1'b1;
      br_valid = 1'b1;
      br_type  = 1'b1;
      ccc      = 3'b111;
      br_reg   = 16'hBEEF;
      #1;
      chk("stall_taken", {31'h0, taken}, 32'h0);
      chk("stall_fv", {31'h0, fetch_valid}, 32'h0);
      tick();
      chk("stall_pc", {16'h0, pc_out}, 32'h1234);
      chk("stall_cnt", {16'h0, br_count}, exp_cnt);
    end
    idle();

    // Halt beats a simultaneous branch; halted is sticky
    br_to(16'h0040);
    halt_req = 1'b1;
    br_valid = 1'b1;
    br_type  = 1'b1;
    ccc      = 3'b111;
    br_reg   = 16'h5555;
    #1;
    chk("halt_taken", {31'h0, taken}, 32'h0);
    tick();
    chk("halt_pc", {16'h0, pc_out}, 32'h0040);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_fv", {31'h0, fetch_valid}, 32'h0);
    halt_req = 1'b0;
    #1;
    chk("halt_taken2", {31'h0, taken}, 32'h0);
    tick();
    halt_req = 1'b1;
    tick();
    chk("halt_pc2", {16'h0, pc_out}, 32'h0040);
    chk("halt_cnt", {16'h0, br_count}, exp_cnt);
    chk("halt_flag2", {31'h0, halted}, 32'h1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("unhalt_pc", {16'h0, pc_out}, 32'h0000);
    chk("unhalt_flag", {31'h0, halted}, 32'h0);
    chk("unhalt_cnt", {16'h0, br_count}, 32'h0);

    // Reset during stall
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_stall_pc", {16'h0, pc_out}, 32'h0000);

    // Wrap-around and odd BR target
    br_to(16'hFFFE);
    chk("wrap_pc2", {16'h0, pc_plus2}, 32'h0000);
    tick();
    chk("wrap_seq", {16'h0, pc_out}, 32'h0000);
    br_to(16'hFFFC);
    br_valid = 1'b1;
    br_type  = 1'b0;
    ccc      = 3'b111;
    imm9     = 9'h003;
    tick();
    idle();
    exp_cnt++;
    chk("wrap_b", {16'h0, pc_out}, 32'h0004);
    br_to(16'h1235);
    chk("odd_br_cnt", {16'h0, br_count}, exp_cnt);

    // Condition sweep
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] cv;
        logic [2:0] fv;
        cv = 3'(c);
        fv = 3'(f);
        br_valid = 1'b1;
        br_type  = 1'b0;
        ccc      = cv;
        flags    = fv;
        imm9     = 9'h000;
        #1;
        chk($sformatf("cond_c%0d_f%0d", c, f), {31'h0, taken},
            {31'h0, ref_cond(cv, fv[2], fv[1], fv[0])});
        br_valid = 1'b0;
        tick();
      end
    end
    idle();

    // Counter saturation on the 2-bit instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      br_valid = 1'b1;
      br_type  = 1'b0;
      ccc      = 3'b111;
      imm9     = 9'h000;
      tick();
      chk("cnt16", {16'h0, br_count}, i);
      chk("cnt2_sat", {30'h0, br_count2}, (i > 3) ? 3 : i);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
